// File: rtl/ccff_chain_loader.sv
// Streams a word-wide bitstream LSB-first into a serial configuration-flip-flop chain.
// Optional macro CCFF_LOADER_READBACK_EN adds a recirculating CRC-16-CCITT readback check.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int CNT_W  = $clog2(2 * CHAIN_LEN + 1);
  localparam int WCNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0]  LAST_TX = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WCNT_W-1:0] LAST_W  = WCNT_W'(WORD_W - 1);

`ifdef CCFF_LOADER_READBACK_EN
  localparam logic [CNT_W-1:0] LAST_RB = CNT_W'(2 * CHAIN_LEN - 1);
  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, VERIFY, FINISH} state_t;

  function automatic logic [15:0] crc_upd(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb      = crc[15] ^ bit_in;
    crc_upd = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  logic [15:0] r_crc_tx;
  logic [15:0] r_crc_rx;
  logic        r_recirc;
  logic        r_error;
`else
  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, FINISH} state_t;
  logic w_unused_tail;
  assign w_unused_tail = ccff_tail;
`endif

  state_t             r_state;
  logic [CNT_W-1:0]   r_bitcnt;
  logic [WCNT_W-1:0]  r_wcnt;
  logic [WORD_W-1:0]  r_shreg;
  logic               r_head;
  logic               r_shift_en;
  logic               r_done;

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_state    <= IDLE;
      r_bitcnt   <= '0;
      r_wcnt     <= '0;
      r_head     <= 1'b0;
      r_shift_en <= 1'b0;
      r_done     <= 1'b0;
`ifdef CCFF_LOADER_READBACK_EN
      r_crc_tx   <= '0;
      r_crc_rx   <= '0;
      r_recirc   <= 1'b0;
      r_error    <= 1'b0;
`endif
    end else begin
      r_shift_en <= 1'b0;
      r_done     <= 1'b0;
`ifdef CCFF_LOADER_READBACK_EN
      r_recirc   <= 1'b0;
      // The bit leaving the tail on each recirculating shift feeds the readback CRC.
      if (r_recirc) r_crc_rx <= crc_upd(r_crc_rx, ccff_tail);
`endif
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state  <= FETCH;
            r_bitcnt <= '0;
            r_wcnt   <= '0;
`ifdef CCFF_LOADER_READBACK_EN
            r_error  <= 1'b0;
            r_crc_tx <= 16'hFFFF;
            r_crc_rx <= 16'hFFFF;
`endif
          end
        end
        FETCH: begin
          if (word_valid) begin
            r_state <= SHIFT;
            r_wcnt  <= '0;
          end
        end
        SHIFT: begin
          r_head     <= r_shreg[0];
          r_shift_en <= 1'b1;
          r_bitcnt   <= r_bitcnt + CNT_W'(1);
          r_wcnt     <= r_wcnt + WCNT_W'(1);
`ifdef CCFF_LOADER_READBACK_EN
          r_crc_tx   <= crc_upd(r_crc_tx, r_shreg[0]);
          if (r_bitcnt == LAST_TX) r_state <= VERIFY;
`else
          if (r_bitcnt == LAST_TX) r_state <= FINISH;
`endif
          else if (r_wcnt == LAST_W) r_state <= FETCH;
        end
`ifdef CCFF_LOADER_READBACK_EN
        VERIFY: begin
          r_shift_en <= 1'b1;
          r_recirc   <= 1'b1;
          r_bitcnt   <= r_bitcnt + CNT_W'(1);
          if (r_bitcnt == LAST_RB) r_state <= FINISH;
        end
`endif
        FINISH: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
`ifdef CCFF_LOADER_READBACK_EN
          // The final tail bit lands on this same edge, so fold it in before comparing.
          r_error <= (r_crc_tx != crc_upd(r_crc_rx, ccff_tail));
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge prog_clk) begin
    if (r_state == FETCH && word_valid) r_shreg <= word_data;
    else if (r_state == SHIFT)          r_shreg <= r_shreg >> 1;
  end

  assign word_ready    = (r_state == FETCH);
  assign busy          = (r_state != IDLE);
  assign ccff_shift_en = r_shift_en;
  assign done          = r_done;
`ifdef CCFF_LOADER_READBACK_EN
  // Tail passes straight to head while recirculating so the loop is exactly CHAIN_LEN long.
  assign ccff_head     = r_recirc ? ccff_tail : r_head;
  assign error         = r_error;
`else
  assign ccff_head     = r_head;
  assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: a 64-bit and a 20-bit chain model behind two instances.
// Readback cases are exercised when CCFF_LOADER_READBACK_EN is defined.
module tb_ccff_chain_loader;

`ifdef CCFF_LOADER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_s  [2];
  logic [7:0] wdata_s  [2];
  logic       wvalid_s [2];
  logic       wready_o [2];
  logic       head_o   [2];
  logic       sen_o    [2];
  logic       tail_s   [2];
  logic       busy_o   [2];
  logic       done_o   [2];
  logic       err_o    [2];
  logic       flip_s   [2];

  logic [63:0] chain0;
  logic [19:0] chain1;

  int n_chk = 0;
  int n_err = 0;
  bit exp_q[$];
  bit sent[64];
  logic [7:0] words[8];

  always #5 clk = ~clk;

  ccff_chain_loader #(.CHAIN_LEN(64), .WORD_W(8)) u_dut0 (
    .prog_clk(clk), .pReset_n(rst_n), .start(start_s[0]), .word_data(wdata_s[0]),
    .word_valid(wvalid_s[0]), .word_ready(wready_o[0]), .ccff_head(head_o[0]),
    .ccff_shift_en(sen_o[0]), .ccff_tail(tail_s[0]), .busy(busy_o[0]),
    .done(done_o[0]), .error(err_o[0]));

  ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_dut1 (
    .prog_clk(clk), .pReset_n(rst_n), .start(start_s[1]), .word_data(wdata_s[1]),
    .word_valid(wvalid_s[1]), .word_ready(wready_o[1]), .ccff_head(head_o[1]),
    .ccff_shift_en(sen_o[1]), .ccff_tail(tail_s[1]), .busy(busy_o[1]),
    .done(done_o[1]), .error(err_o[1]));

  // Behavioural chains: head enters bit 0, tail is the top bit; flip_s corrupts the tail-side bit.
  always @(posedge clk) if (sen_o[0]) chain0 <= {chain0[62:0], head_o[0]} ^ {flip_s[0], 63'b0};
  always @(posedge clk) if (sen_o[1]) chain1 <= {chain1[18:0], head_o[1]} ^ {flip_s[1], 19'b0};
  assign tail_s[0] = chain0[63];
  assign tail_s[1] = chain1[19];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_load(input int d, input int stall_word, input bit busy_start,
                         input bit flip, input int abort_bit);
    int cl, cyc, sh, acc, pushed, stall_n, done_cyc, exp_lat, exp_total;
    bit was_stall, stalling, last_head, rb_pushed;
    logic [63:0] ev, gv;
    cl        = (d == 0) ? 64 : 20;
    exp_total = RB ? 2 * cl : cl;
    exp_lat   = cl + (cl + 7) / 8 + 2 + (RB ? cl : 0) + ((stall_word >= 0) ? 5 : 0);
    exp_q.delete();
    pushed = 0; acc = 0; sh = 0; stall_n = 0; done_cyc = -1; cyc = 0;
    was_stall = 0; last_head = 0; rb_pushed = 0;
    @(negedge clk);
    start_s[d]  = 1'b1;
    wvalid_s[d] = 1'b1;
    wdata_s[d]  = words[0];
    while (done_cyc < 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start_s[d] = busy_start && (cyc == 30);
      flip_s[d]  = 1'b0;
      if (was_stall) begin
        chk("stall_shift_en", 64'(sen_o[d]), 64'(0));
        chk("stall_head_hold", 64'(head_o[d]), 64'(last_head));
      end
      if (sen_o[d]) begin
        sh++;
        last_head = head_o[d];
        if (exp_q.size() > 0) chk("head_bit", 64'(head_o[d]), 64'(exp_q.pop_front()));
        else chk("shift_overrun", 64'(sh), 64'(exp_total));
        if (sh == cl) flip_s[d] = flip;
      end
      if (done_o[d]) done_cyc = cyc;
      if (abort_bit >= 0 && sh == abort_bit) begin
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 64'(wready_o[d]), 64'(0));
        chk("abort_head", 64'(head_o[d]), 64'(0));
        chk("abort_shift_en", 64'(sen_o[d]), 64'(0));
        chk("abort_busy", 64'(busy_o[d]), 64'(0));
        chk("abort_done", 64'(done_o[d]), 64'(0));
        chk("abort_error", 64'(err_o[d]), 64'(0));
        exp_q.delete();
        start_s[d]  = 1'b0;
        wvalid_s[d] = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("abort_no_done", 64'(done_o[d]), 64'(0));
        end
        rst_n = 1'b1;
        return;
      end
      stalling = (acc == stall_word) && wready_o[d] && (stall_n < 5);
      if (stalling) stall_n++;
      was_stall   = stalling;
      wvalid_s[d] = !stalling;
      wdata_s[d]  = words[(acc < 8) ? acc : 0];
      if (wready_o[d] && wvalid_s[d]) begin
        for (int b = 0; b < 8; b++) begin
          if (pushed < cl) begin
            sent[pushed] = wdata_s[d][b];
            exp_q.push_back(sent[pushed]);
            pushed++;
          end
        end
        acc++;
        if (RB && pushed == cl && !rb_pushed) begin
          rb_pushed = 1'b1;
          for (int k = 0; k < cl; k++) exp_q.push_back(sent[k] ^ (flip && k == 0));
        end
      end
    end
    wvalid_s[d] = 1'b0;
    if (done_cyc < 0) chk("done_timeout", 64'(cyc), 64'(exp_lat));
    else chk("done_latency", 64'(done_cyc), 64'(exp_lat));
    chk("shift_count", 64'(sh), 64'(exp_total));
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    chk("words_taken", 64'(acc), 64'((cl + 7) / 8));
    chk("error_flag", 64'(err_o[d]), 64'(flip));
    ev = '0;
    for (int k = 0; k < cl; k++) ev[cl-1-k] = sent[k];
    if (flip) ev[cl-1] = ~ev[cl-1];
    gv = (d == 0) ? chain0 : {44'b0, chain1};
    chk("chain_contents", gv, ev);
    @(negedge clk);
    chk("done_one_cycle", 64'(done_o[d]), 64'(0));
    chk("idle_busy", 64'(busy_o[d]), 64'(0));
    chk("error_sticky", 64'(err_o[d]), 64'(flip));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; wdata_s[d] = '0; wvalid_s[d] = 1'b0; flip_s[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", 64'(wready_o[d]), 64'(0));
      chk("rst_head", 64'(head_o[d]), 64'(0));
      chk("rst_shift_en", 64'(sen_o[d]), 64'(0));
      chk("rst_busy", 64'(busy_o[d]), 64'(0));
      chk("rst_done", 64'(done_o[d]), 64'(0));
      chk("rst_error", 64'(err_o[d]), 64'(0));
    end
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) words[i] = 8'(i + 1);
    do_load(0, -1, 1'b0, 1'b0, -1);

    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hF6; words[3] = 8'h99;
    do_load(1, -1, 1'b0, 1'b0, -1);

    for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
    do_load(0, 3, 1'b0, 1'b0, -1);

    for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
    do_load(0, -1, 1'b1, 1'b0, -1);

`ifdef CCFF_LOADER_READBACK_EN
    for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
    do_load(0, -1, 1'b0, 1'b1, -1);
    do_load(0, -1, 1'b0, 1'b0, -1);
`endif

    for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
    do_load(0, -1, 1'b0, 1'b0, 30);
    for (int i = 0; i < 8; i++) words[i] = 8'($urandom);
    do_load(0, -1, 1'b0, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
